// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the two-port memory arbiter.
// master = requester/memory side, slave = arbiter side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  i_req;
    logic [ADDR_W-1:0]     i_addr;
    logic                  i_done;
    logic [DATA_W-1:0]     i_rdata;
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_be;
    logic                  d_done;
    logic [DATA_W-1:0]     d_rdata;
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_ack;
    logic                  bus_err;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ack,
        output i_done, i_rdata, d_done, d_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               mem_be, bus_err
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata, mem_ack,
        input  i_done, i_rdata, d_done, d_rdata, mem_en, mem_we, mem_addr, mem_wdata,
               mem_be, bus_err
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and data
// access, one outstanding access at a time, with an ack timeout.
//
// state  | meaning
// IDLE   | no access outstanding; requests sampled here
// BUSY_I | fetch access on the memory port, waiting for mem_ack
// BUSY_D | load/store access on the memory port, waiting for mem_ack
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t             state, state_nxt;
    logic               last_d;
    logic [CNT_W-1:0]   cnt;
    logic               en_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [BE_W-1:0]    be_q;
    logic               gnt_i;
    logic               gnt_d;
    logic               timeout;
    logic               finish;

    always_comb begin
        state_nxt = state;
        gnt_i     = 1'b0;
        gnt_d     = 1'b0;
        timeout   = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                // on a tie the side not served last wins
                if (bus.i_req && (!bus.d_req || last_d)) begin
                    gnt_i     = 1'b1;
                    state_nxt = BUSY_I;
                end else if (bus.d_req) begin
                    gnt_d     = 1'b1;
                    state_nxt = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                timeout = !bus.mem_ack && (cnt == CNT_W'(TIMEOUT));
                finish  = bus.mem_ack || timeout;
                if (finish) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            last_d  <= 1'b1;
            cnt     <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state <= state_nxt;
            if (gnt_i) begin
                last_d  <= 1'b0;
                cnt     <= '0;
                en_q    <= 1'b1;
                we_q    <= 1'b0;
                addr_q  <= bus.i_addr;
                wdata_q <= '0;
                be_q    <= '1;
            end else if (gnt_d) begin
                last_d  <= 1'b1;
                cnt     <= '0;
                en_q    <= 1'b1;
                we_q    <= bus.d_we;
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
                be_q    <= bus.d_be;
            end else if (finish) begin
                en_q <= 1'b0;
            end else if (state != IDLE) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // reset gating keeps a pending ack from completing an abandoned access
    assign bus.i_done    = rst && finish && (state == BUSY_I);
    assign bus.d_done    = rst && finish && (state == BUSY_D);
    assign bus.bus_err   = rst && timeout;
    assign bus.i_rdata   = timeout ? '0 : bus.mem_rdata;
    assign bus.d_rdata   = timeout ? '0 : bus.mem_rdata;
    assign bus.mem_en    = en_q;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_be    = be_q;
endmodule
